// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART blocks (uart_rx, uart_tx, uart_rx_fifo).
//   UART_DATA_WIDTH       default character width
//   UART_FIFO_DEPTH_LOG2  default receive FIFO depth exponent (2**N entries)
//   sat_inc8()            saturating 8-bit increment used by statistics counters
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_WIDTH      = 8;
    localparam int UART_FIFO_DEPTH_LOG2 = 4;

    // Increment that sticks at 255 instead of wrapping back to 0.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage : uart_pkg

// File: rtl/rise_detect.sv
// ----------------------------------------------------------------------------
// rise_detect
// Registered rising-edge detector. `rise` is high for the cycle in which `d`
// is 1 and its registered copy is still 0. RESET_VAL selects the assumed
// previous level after reset: 1 suppresses an edge for a level that is
// already high when reset releases.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   d      level input (already synchronous to clk)
//   rise   combinational rising-edge pulse
// ----------------------------------------------------------------------------
module rise_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    // NOTE: sequential state is assigned with <= so every flop samples its
    // inputs from before the edge, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= RESET_VAL;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule : rise_detect

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side buffer for uart_rx. Captures one byte on each rising edge of
// uart_rx's level-held ready, drops frames flagged with a framing error, and
// buffers good bytes in a 2**DEPTH_LOG2 first-word-fall-through FIFO that is
// drained over a valid/ready stream.
//
// Optional feature (compile-time macro UART_RX_FIFO_STATS_EN):
//   adds err_count[7:0] (error frames seen) and drop_count[7:0] (bytes lost
//   to overflow); both saturate at 255 and clear on clear_overflow.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   rx_ready        uart_rx ready level, high while a byte is held
//   rx_error        uart_rx framing error for the held frame
//   rx_data         uart_rx received byte
//   out_data        head-of-FIFO byte, valid when out_valid=1
//   out_valid       FIFO non-empty
//   out_ready       consumer takes out_data this cycle when out_valid=1
//   level           occupancy 0..DEPTH
//   full            level == DEPTH
//   overflow        sticky: a good byte was dropped because the FIFO was full
//   clear_overflow  synchronous clear of overflow (and statistics)
// ----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_ready,
    input  logic                  rx_error,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  overflow,
`ifdef UART_RX_FIFO_STATS_EN
    output logic [7:0]            err_count,
    output logic [7:0]            drop_count,
`endif
    input  logic                  clear_overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the indices coincide.
    logic [DEPTH_LOG2:0]   wr_ptr;
    logic [DEPTH_LOG2:0]   rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic push_evt;
    logic push_good;
    logic pop;
    logic wr_en;
    logic drop;
    logic empty;

    // Reset value 1: a byte already held when reset releases is treated as
    // stale and is not captured.
    rise_detect #(
        .RESET_VAL (1'b1)
    ) u_ready_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_ready),
        .rise  (push_evt)
    );

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                   (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
    assign level = wr_ptr - rd_ptr;

    assign out_valid = ~empty;
    assign out_data  = mem[rd_ptr[DEPTH_LOG2-1:0]];

    assign pop       = out_valid & out_ready;
    assign push_good = push_evt & ~rx_error;
    // A simultaneous pop frees the head slot at the same edge, so a full FIFO
    // can still accept the byte; the write lands on the slot being vacated.
    assign wr_en     = push_good & (~full | pop);
    assign drop      = push_good & full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; stale contents are never visible
    // because reset empties the pointers, and a reset-free array can map to RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= rx_data;
        end
    end

    // Set has priority so a drop coinciding with a clear is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_STATS_EN
    logic err_evt;

    assign err_evt = push_evt & rx_error;

    // On clear, an event in the same cycle still counts: the counter restarts at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count  <= 8'd0;
            drop_count <= 8'd0;
        end else if (clear_overflow) begin
            err_count  <= {7'd0, err_evt};
            drop_count <= {7'd0, drop};
        end else begin
            if (err_evt) begin
                err_count <= sat_inc8(err_count);
            end
            if (drop) begin
                drop_count <= sat_inc8(drop_count);
            end
        end
    end
`endif

endmodule : uart_rx_fifo
